// File: rtl/reorder_buffer_if.sv
// Bundle of issue, dispatch, CDB, RS-forward and commit signals around the
// reorder buffer. The ROB takes the slave side; the surrounding core (or a
// bench) takes the master side.
//
// Handshake semantics: every *_en strobe is a single-cycle valid qualifier
// with no ready/backpressure; the payload is only meaningful in a cycle where
// its strobe is high. The only flow control is full_o, which the issuer must
// observe before raising iss_en_i (an issue while full is dropped).
interface reorder_buffer_if #(
    parameter int ROB_BIT = 4,
    parameter int REG_BIT = 5,
    parameter int DAT_W   = 32,
    parameter int ADR_W   = 32,
    parameter int OP_W    = 6
);
    // issue
    logic               iss_en_i;
    logic [REG_BIT-1:0] iss_rd_i;
    logic [ROB_BIT-1:0] tail_o;
    logic               full_o;
    // dispatch from register_file
    logic               dp_en_i;
    logic               dp_ic_i;
    logic               dp_ls_i;
    logic [ROB_BIT-1:0] dp_qd_i;
    logic [ROB_BIT-1:0] dp_qj_i;
    logic [ROB_BIT-1:0] dp_qk_i;
    logic [DAT_W-1:0]   dp_vj_i;
    logic [DAT_W-1:0]   dp_vk_i;
    logic [OP_W-1:0]    dp_op_i;
    logic [DAT_W-1:0]   dp_imm_i;
    logic [ADR_W-1:0]   dp_pc_i;
    // common data bus
    logic               cdb_en_i;
    logic [ROB_BIT-1:0] cdb_q_i;
    logic [DAT_W-1:0]   cdb_v_i;
    // forward to reservation stations
    logic               rs_en_o;
    logic               rs_ic_o;
    logic               rs_ls_o;
    logic [ROB_BIT-1:0] rs_qj_o;
    logic [ROB_BIT-1:0] rs_qk_o;
    logic [ROB_BIT-1:0] rs_qd_o;
    logic [DAT_W-1:0]   rs_vj_o;
    logic [DAT_W-1:0]   rs_vk_o;
    logic [OP_W-1:0]    rs_op_o;
    logic [DAT_W-1:0]   rs_imm_o;
    logic [ADR_W-1:0]   rs_pc_o;
    // commit
    logic               cm_en_o;
    logic [REG_BIT-1:0] cm_rd_o;
    logic [ROB_BIT-1:0] cm_q_o;
    logic [DAT_W-1:0]   cm_v_o;
    logic               st_cm_o;
    logic [ROB_BIT-1:0] st_q_o;
    // debug view of the queue pointers
    logic [ROB_BIT-1:0] dbg_head_o;
    logic [ROB_BIT-1:0] dbg_count_o;

    modport slave (
        input  iss_en_i, iss_rd_i,
        input  dp_en_i, dp_ic_i, dp_ls_i, dp_qd_i, dp_qj_i, dp_qk_i,
        input  dp_vj_i, dp_vk_i, dp_op_i, dp_imm_i, dp_pc_i,
        input  cdb_en_i, cdb_q_i, cdb_v_i,
        output tail_o, full_o,
        output rs_en_o, rs_ic_o, rs_ls_o, rs_qj_o, rs_qk_o, rs_qd_o,
        output rs_vj_o, rs_vk_o, rs_op_o, rs_imm_o, rs_pc_o,
        output cm_en_o, cm_rd_o, cm_q_o, cm_v_o, st_cm_o, st_q_o,
        output dbg_head_o, dbg_count_o
    );

    modport master (
        output iss_en_i, iss_rd_i,
        output dp_en_i, dp_ic_i, dp_ls_i, dp_qd_i, dp_qj_i, dp_qk_i,
        output dp_vj_i, dp_vk_i, dp_op_i, dp_imm_i, dp_pc_i,
        output cdb_en_i, cdb_q_i, cdb_v_i,
        input  tail_o, full_o,
        input  rs_en_o, rs_ic_o, rs_ls_o, rs_qj_o, rs_qk_o, rs_qd_o,
        input  rs_vj_o, rs_vk_o, rs_op_o, rs_imm_o, rs_pc_o,
        input  cm_en_o, cm_rd_o, cm_q_o, cm_v_o, st_cm_o, st_q_o,
        input  dbg_head_o, dbg_count_o
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, resolves operand tags of
// dispatched bundles against completed entries and the CDB, forwards the
// bundle to the reservation stations, and retires in order one per cycle.
// Tag 0 means "no producer" and is never allocated.
module reorder_buffer #(
    parameter int ROB_BIT   = 4,
    parameter int REG_BIT   = 5,
    parameter int DAT_W     = 32,
    parameter int ADR_W     = 32,
    parameter int OP_W      = 6,
    // Opcodes in [ST_OP_LO, ST_OP_HI] with ls=1 are stores (retire to LSB).
    parameter int ST_OP_LO  = 24,
    parameter int ST_OP_HI  = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic flush_i,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_BIT;
    localparam logic [ROB_BIT-1:0] TAG_FIRST = ROB_BIT'(1);
    localparam logic [ROB_BIT-1:0] TAG_LAST  = ROB_BIT'(DEPTH - 1);
    localparam logic [OP_W-1:0]    ST_LO     = OP_W'(ST_OP_LO);
    localparam logic [OP_W-1:0]    ST_HI     = OP_W'(ST_OP_HI);

    // Per-entry state
    logic [DEPTH-1:0]   busy_q, filled_q, ready_q, is_st_q;
    logic [REG_BIT-1:0] rd_q  [DEPTH];
    logic [DAT_W-1:0]   val_q [DEPTH];

    logic [ROB_BIT-1:0] head_q, tail_q, count_q;

    // Registered outputs
    logic               rs_en_q, rs_ic_q, rs_ls_q;
    logic [ROB_BIT-1:0] rs_qj_q, rs_qk_q, rs_qd_q;
    logic [DAT_W-1:0]   rs_vj_q, rs_vk_q, rs_imm_q;
    logic [OP_W-1:0]    rs_op_q;
    logic [ADR_W-1:0]   rs_pc_q;
    logic               cm_en_q, st_cm_q;
    logic [REG_BIT-1:0] cm_rd_q;
    logic [ROB_BIT-1:0] cm_q_q, st_tag_q;
    logic [DAT_W-1:0]   cm_v_q;

    logic               full, alloc, commit, fill, cdb_hit, store_op, head_is_st;
    logic [ROB_BIT-1:0] qj_res, qk_res;
    logic [DAT_W-1:0]   vj_res, vk_res;

    function automatic logic [ROB_BIT-1:0] tag_next(input logic [ROB_BIT-1:0] t);
        return (t == TAG_LAST) ? TAG_FIRST : t + 1'b1;
    endfunction

    assign full       = (count_q == TAG_LAST);
    assign alloc      = en && rob.iss_en_i && !full;
    assign commit     = en && busy_q[head_q] && filled_q[head_q] && ready_q[head_q];
    assign fill       = en && rob.dp_en_i;
    assign cdb_hit    = en && rob.cdb_en_i && busy_q[rob.cdb_q_i];
    assign store_op   = rob.dp_ls_i && (rob.dp_op_i >= ST_LO) && (rob.dp_op_i <= ST_HI);
    assign head_is_st = is_st_q[head_q];

    // Resolve source tags from pre-edge ROB state, then from the same-cycle CDB.
    always_comb begin
        qj_res = rob.dp_qj_i;
        vj_res = rob.dp_vj_i;
        qk_res = rob.dp_qk_i;
        vk_res = rob.dp_vk_i;
        if (rob.dp_qj_i != '0) begin
            if (ready_q[rob.dp_qj_i]) begin
                qj_res = '0;
                vj_res = val_q[rob.dp_qj_i];
            end else if (rob.cdb_en_i && rob.cdb_q_i == rob.dp_qj_i) begin
                qj_res = '0;
                vj_res = rob.cdb_v_i;
            end
        end
        if (rob.dp_qk_i != '0) begin
            if (ready_q[rob.dp_qk_i]) begin
                qk_res = '0;
                vk_res = val_q[rob.dp_qk_i];
            end else if (rob.cdb_en_i && rob.cdb_q_i == rob.dp_qk_i) begin
                qk_res = '0;
                vk_res = rob.cdb_v_i;
            end
        end
    end

    // Control state: pointers, count and per-entry flags. Allocation is applied
    // last so it overrides any stale flags of the entry being reused.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q   <= TAG_FIRST;
            tail_q   <= TAG_FIRST;
            count_q  <= '0;
            busy_q   <= '0;
            filled_q <= '0;
            ready_q  <= '0;
            is_st_q  <= '0;
        end else if (en) begin
            if (cdb_hit) ready_q[rob.cdb_q_i] <= 1'b1;
            if (fill) begin
                filled_q[rob.dp_qd_i] <= 1'b1;
                is_st_q[rob.dp_qd_i]  <= store_op;
            end
            if (commit) begin
                busy_q[head_q] <= 1'b0;
                head_q         <= tag_next(head_q);
            end
            if (alloc) begin
                busy_q[tail_q]   <= 1'b1;
                filled_q[tail_q] <= 1'b0;
                ready_q[tail_q]  <= 1'b0;
                tail_q           <= tag_next(tail_q);
            end
            case ({alloc, commit})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload (destination and result value); no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && en) begin
            if (cdb_hit) val_q[rob.cdb_q_i] <= rob.cdb_v_i;
            if (alloc)   rd_q[tail_q]       <= rob.iss_rd_i;
        end
    end

    // Output registers: RS forward one cycle after dispatch, commit pulses.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rs_en_q  <= 1'b0;  rs_ic_q <= 1'b0;  rs_ls_q <= 1'b0;
            rs_qj_q  <= '0;    rs_qk_q <= '0;    rs_qd_q <= '0;
            rs_vj_q  <= '0;    rs_vk_q <= '0;    rs_imm_q <= '0;
            rs_op_q  <= '0;    rs_pc_q <= '0;
            cm_en_q  <= 1'b0;  st_cm_q <= 1'b0;
            cm_rd_q  <= '0;    cm_q_q  <= '0;    cm_v_q <= '0;
            st_tag_q <= '0;
        end else if (!en) begin
            rs_en_q <= 1'b0;
            cm_en_q <= 1'b0;
            st_cm_q <= 1'b0;
        end else begin
            rs_en_q <= fill;
            if (fill) begin
                rs_ic_q  <= rob.dp_ic_i;
                rs_ls_q  <= rob.dp_ls_i;
                rs_qd_q  <= rob.dp_qd_i;
                rs_qj_q  <= qj_res;
                rs_qk_q  <= qk_res;
                rs_vj_q  <= vj_res;
                rs_vk_q  <= vk_res;
                rs_op_q  <= rob.dp_op_i;
                rs_imm_q <= rob.dp_imm_i;
                rs_pc_q  <= rob.dp_pc_i;
            end
            cm_en_q <= commit && !head_is_st;
            st_cm_q <= commit && head_is_st;
            if (commit && !head_is_st) begin
                cm_rd_q <= rd_q[head_q];
                cm_q_q  <= head_q;
                cm_v_q  <= val_q[head_q];
            end
            if (commit && head_is_st) st_tag_q <= head_q;
        end
    end

    assign rob.tail_o      = tail_q;
    assign rob.full_o      = full;
    assign rob.rs_en_o     = rs_en_q && en;
    assign rob.rs_ic_o     = rs_ic_q;
    assign rob.rs_ls_o     = rs_ls_q;
    assign rob.rs_qj_o     = rs_qj_q;
    assign rob.rs_qk_o     = rs_qk_q;
    assign rob.rs_qd_o     = rs_qd_q;
    assign rob.rs_vj_o     = rs_vj_q;
    assign rob.rs_vk_o     = rs_vk_q;
    assign rob.rs_op_o     = rs_op_q;
    assign rob.rs_imm_o    = rs_imm_q;
    assign rob.rs_pc_o     = rs_pc_q;
    assign rob.cm_en_o     = cm_en_q && en;
    assign rob.cm_rd_o     = cm_rd_q;
    assign rob.cm_q_o      = cm_q_q;
    assign rob.cm_v_o      = cm_v_q;
    assign rob.st_cm_o     = st_cm_q && en;
    assign rob.st_q_o      = st_tag_q;
    assign rob.dbg_head_o  = head_q;
    assign rob.dbg_count_o = count_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset/idle, single instruction round
// trip, wrap-around and full, operand resolution, in-order commit with store
// and load retirement, flush and global enable freeze.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic flush_i = 1'b0;
    int   total = 0;
    int   pass = 0;

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush_i (flush_i),
        .rob     (rif)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rif.iss_en_i = 1'b0; rif.iss_rd_i = '0;
        rif.dp_en_i = 1'b0;  rif.dp_ic_i = 1'b0; rif.dp_ls_i = 1'b0;
        rif.dp_qd_i = '0;    rif.dp_qj_i = '0;   rif.dp_qk_i = '0;
        rif.dp_vj_i = '0;    rif.dp_vk_i = '0;   rif.dp_op_i = '0;
        rif.dp_imm_i = '0;   rif.dp_pc_i = '0;
        rif.cdb_en_i = 1'b0; rif.cdb_q_i = '0;   rif.cdb_v_i = '0;
        flush_i = 1'b0;
    endtask

    // Advance one edge, sample 1 ns later, then drop all strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic drive_iss(input logic [4:0] rd);
        rif.iss_en_i = 1'b1; rif.iss_rd_i = rd;
    endtask

    task automatic drive_dp(input logic [3:0] qd, input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] qk, input logic [31:0] vk,
                            input logic ls, input logic [5:0] op);
        rif.dp_en_i = 1'b1; rif.dp_qd_i = qd; rif.dp_qj_i = qj; rif.dp_vj_i = vj;
        rif.dp_qk_i = qk;   rif.dp_vk_i = vk; rif.dp_ls_i = ls; rif.dp_op_i = op;
        rif.dp_ic_i = 1'b1; rif.dp_imm_i = 32'h10; rif.dp_pc_i = 32'h100;
    endtask

    task automatic drive_cdb(input logic [3:0] q, input logic [31:0] v);
        rif.cdb_en_i = 1'b1; rif.cdb_q_i = q; rif.cdb_v_i = v;
    endtask

    task automatic do_reset();
        clear_inputs();
        en = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rif.tail_o !== 4'd1 || rif.full_o !== 1'b0 || rif.dbg_head_o !== 4'd1 || rif.dbg_count_o !== 4'd0)
                $display("FAIL reset_ptrs cyc%0d got tail=%0d full=%0d head=%0d cnt=%0d exp 1/0/1/0",
                         i, rif.tail_o, rif.full_o, rif.dbg_head_o, rif.dbg_count_o);
            else pass++;
            total++;
            if ({rif.rs_en_o, rif.cm_en_o, rif.st_cm_o} !== 3'b000)
                $display("FAIL reset_pulses cyc%0d got %b exp 000", i, {rif.rs_en_o, rif.cm_en_o, rif.st_cm_o});
            else pass++;
            tick();
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive_iss(5'd5);
        tick();
        total++;
        if (rif.tail_o !== 4'd2) $display("FAIL basic_tail got %0d exp 2", rif.tail_o); else pass++;
        drive_dp(4'd1, 4'd0, 32'd7, 4'd0, 32'd0, 1'b0, 6'd1);
        drive_cdb(4'd1, 32'h2A);
        tick();
        total++;
        if ({rif.rs_en_o, rif.rs_qd_o, rif.rs_qj_o, rif.rs_vj_o} !== {1'b1, 4'd1, 4'd0, 32'd7})
            $display("FAIL basic_rs got en=%0d qd=%0d qj=%0d vj=%0h exp 1/1/0/7",
                     rif.rs_en_o, rif.rs_qd_o, rif.rs_qj_o, rif.rs_vj_o);
        else pass++;
        total++;
        if ({rif.rs_pc_o, rif.rs_imm_o, rif.rs_ic_o, rif.cm_en_o} !== {32'h100, 32'h10, 1'b1, 1'b0})
            $display("FAIL basic_rs_pass got pc=%0h imm=%0h ic=%0d cm=%0d exp 100/10/1/0",
                     rif.rs_pc_o, rif.rs_imm_o, rif.rs_ic_o, rif.cm_en_o);
        else pass++;
        tick();
        total++;
        if ({rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o, rif.rs_en_o} !== {1'b1, 5'd5, 4'd1, 32'h2A, 1'b0})
            $display("FAIL basic_commit got en=%0d rd=%0d q=%0d v=%0h rs=%0d exp 1/5/1/2a/0",
                     rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o, rif.rs_en_o);
        else pass++;
        total++;
        if (rif.dbg_head_o !== 4'd2 || rif.dbg_count_o !== 4'd0)
            $display("FAIL basic_ptrs got head=%0d cnt=%0d exp 2/0", rif.dbg_head_o, rif.dbg_count_o);
        else pass++;
        tick();
        total++;
        if (rif.cm_en_o !== 1'b0) $display("FAIL basic_pulse_len got %0d exp 0", rif.cm_en_o); else pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            drive_iss(5'(i));
            tick();
        end
        total++;
        if (rif.tail_o !== 4'd15 || rif.full_o !== 1'b0)
            $display("FAIL full_14 got tail=%0d full=%0d exp 15/0", rif.tail_o, rif.full_o);
        else pass++;
        drive_iss(5'd15);
        tick();
        total++;
        if (rif.tail_o !== 4'd1 || rif.full_o !== 1'b1 || rif.dbg_count_o !== 4'd15)
            $display("FAIL full_wrap got tail=%0d full=%0d cnt=%0d exp 1/1/15",
                     rif.tail_o, rif.full_o, rif.dbg_count_o);
        else pass++;
        drive_iss(5'd16);
        tick();
        total++;
        if (rif.tail_o !== 4'd1 || rif.dbg_count_o !== 4'd15 || rif.full_o !== 1'b1)
            $display("FAIL full_ignore got tail=%0d cnt=%0d full=%0d exp 1/15/1",
                     rif.tail_o, rif.dbg_count_o, rif.full_o);
        else pass++;
    endtask

    task automatic test_resolve();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive_iss(5'(i));
            tick();
        end
        drive_cdb(4'd3, 32'h55);
        tick();
        drive_iss(5'd5);
        tick();
        drive_dp(4'd5, 4'd3, 32'hDEAD, 4'd4, 32'hBEEF, 1'b0, 6'd2);
        drive_cdb(4'd4, 32'h66);
        tick();
        total++;
        if ({rif.rs_en_o, rif.rs_qd_o, rif.rs_qj_o, rif.rs_vj_o} !== {1'b1, 4'd5, 4'd0, 32'h55})
            $display("FAIL resolve_rob got en=%0d qd=%0d qj=%0d vj=%0h exp 1/5/0/55",
                     rif.rs_en_o, rif.rs_qd_o, rif.rs_qj_o, rif.rs_vj_o);
        else pass++;
        total++;
        if (rif.rs_qk_o !== 4'd0 || rif.rs_vk_o !== 32'h66)
            $display("FAIL resolve_cdb got qk=%0d vk=%0h exp 0/66", rif.rs_qk_o, rif.rs_vk_o);
        else pass++;
        // unresolved producer passes through
        drive_iss(5'd6);
        tick();
        drive_dp(4'd6, 4'd2, 32'h11, 4'd0, 32'h99, 1'b0, 6'd2);
        tick();
        total++;
        if ({rif.rs_qj_o, rif.rs_vj_o, rif.rs_qk_o, rif.rs_vk_o} !== {4'd2, 32'h11, 4'd0, 32'h99})
            $display("FAIL resolve_pass got qj=%0d vj=%0h qk=%0d vk=%0h exp 2/11/0/99",
                     rif.rs_qj_o, rif.rs_vj_o, rif.rs_qk_o, rif.rs_vk_o);
        else pass++;
        // CDB aimed at a non-busy tag leaves it unready
        drive_cdb(4'd9, 32'h77);
        drive_iss(5'd7);
        tick();
        drive_dp(4'd7, 4'd9, 32'h3, 4'd0, 32'h0, 1'b0, 6'd2);
        tick();
        total++;
        if (rif.rs_qj_o !== 4'd9 || rif.rs_vj_o !== 32'h3)
            $display("FAIL resolve_nonbusy got qj=%0d vj=%0h exp 9/3", rif.rs_qj_o, rif.rs_vj_o);
        else pass++;
    endtask

    task automatic test_order();
        do_reset();
        drive_iss(5'd1);
        tick();
        drive_iss(5'd2);
        drive_dp(4'd1, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 6'd1);
        tick();
        drive_dp(4'd2, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 6'd1);
        tick();
        drive_cdb(4'd2, 32'hB2);
        tick();
        total++;
        if (rif.cm_en_o !== 1'b0) $display("FAIL order_wait2 got %0d exp 0", rif.cm_en_o); else pass++;
        drive_cdb(4'd1, 32'hB1);
        tick();
        total++;
        if (rif.cm_en_o !== 1'b0) $display("FAIL order_cdb_lat got %0d exp 0", rif.cm_en_o); else pass++;
        tick();
        total++;
        if ({rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o} !== {1'b1, 5'd1, 4'd1, 32'hB1})
            $display("FAIL order_first got en=%0d rd=%0d q=%0d v=%0h exp 1/1/1/b1",
                     rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o);
        else pass++;
        tick();
        total++;
        if ({rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o} !== {1'b1, 5'd2, 4'd2, 32'hB2})
            $display("FAIL order_second got en=%0d rd=%0d q=%0d v=%0h exp 1/2/2/b2",
                     rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o);
        else pass++;
        // store retires to the LSB
        drive_iss(5'd0);
        tick();
        drive_dp(4'd3, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 6'd24);
        drive_cdb(4'd3, 32'd0);
        tick();
        total++;
        if (rif.st_cm_o !== 1'b0 || rif.cm_en_o !== 1'b0)
            $display("FAIL store_early got st=%0d cm=%0d exp 0/0", rif.st_cm_o, rif.cm_en_o);
        else pass++;
        tick();
        total++;
        if ({rif.st_cm_o, rif.st_q_o, rif.cm_en_o} !== {1'b1, 4'd3, 1'b0})
            $display("FAIL store_commit got st=%0d q=%0d cm=%0d exp 1/3/0", rif.st_cm_o, rif.st_q_o, rif.cm_en_o);
        else pass++;
        // load (ls=1, non-store opcode) with rd=0 still pulses cm_en_o
        drive_iss(5'd0);
        tick();
        drive_dp(4'd4, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 6'd20);
        drive_cdb(4'd4, 32'h44);
        tick();
        tick();
        total++;
        if ({rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o, rif.st_cm_o} !== {1'b1, 5'd0, 4'd4, 32'h44, 1'b0})
            $display("FAIL load_rd0 got en=%0d rd=%0d q=%0d v=%0h st=%0d exp 1/0/4/44/0",
                     rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o, rif.st_cm_o);
        else pass++;
    endtask

    task automatic test_flush_en();
        do_reset();
        drive_iss(5'd1);
        tick();
        drive_iss(5'd2);
        drive_dp(4'd1, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 6'd1);
        tick();
        for (int i = 3; i <= 5; i++) begin
            drive_iss(5'(i));
            tick();
        end
        drive_iss(5'd6);
        drive_cdb(4'd1, 32'h5);
        tick();
        total++;
        if (rif.dbg_count_o !== 4'd6 || rif.tail_o !== 4'd7)
            $display("FAIL flush_pre got cnt=%0d tail=%0d exp 6/7", rif.dbg_count_o, rif.tail_o);
        else pass++;
        flush_i = 1'b1;
        drive_iss(5'd9);
        tick();
        total++;
        if ({rif.tail_o, rif.dbg_head_o, rif.dbg_count_o, rif.full_o} !== {4'd1, 4'd1, 4'd0, 1'b0})
            $display("FAIL flush_ptrs got tail=%0d head=%0d cnt=%0d full=%0d exp 1/1/0/0",
                     rif.tail_o, rif.dbg_head_o, rif.dbg_count_o, rif.full_o);
        else pass++;
        total++;
        if ({rif.cm_en_o, rif.st_cm_o, rif.rs_en_o} !== 3'b000)
            $display("FAIL flush_pulses got %b exp 000", {rif.cm_en_o, rif.st_cm_o, rif.rs_en_o});
        else pass++;
        tick();
        total++;
        if (rif.cm_en_o !== 1'b0) $display("FAIL flush_after got %0d exp 0", rif.cm_en_o); else pass++;
        // enable freeze with a commit pending
        drive_iss(5'd3);
        tick();
        drive_dp(4'd1, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 6'd1);
        drive_cdb(4'd1, 32'h5A);
        tick();
        total++;
        if (rif.rs_en_o !== 1'b1) $display("FAIL en_rs_before got %0d exp 1", rif.rs_en_o); else pass++;
        for (int i = 0; i < 3; i++) begin
            en = 1'b0;
            drive_iss(5'd4);
            tick();
            total++;
            if ({rif.cm_en_o, rif.rs_en_o, rif.st_cm_o, rif.tail_o, rif.dbg_count_o, rif.dbg_head_o}
                !== {3'b000, 4'd2, 4'd1, 4'd1})
                $display("FAIL en_freeze cyc%0d got cm=%0d rs=%0d st=%0d tail=%0d cnt=%0d head=%0d exp 0/0/0/2/1/1",
                         i, rif.cm_en_o, rif.rs_en_o, rif.st_cm_o, rif.tail_o, rif.dbg_count_o, rif.dbg_head_o);
            else pass++;
        end
        en = 1'b1;
        tick();
        total++;
        if ({rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o, rif.tail_o} !== {1'b1, 5'd3, 4'd1, 32'h5A, 4'd2})
            $display("FAIL en_resume got en=%0d rd=%0d q=%0d v=%0h tail=%0d exp 1/3/1/5a/2",
                     rif.cm_en_o, rif.cm_rd_o, rif.cm_q_o, rif.cm_v_o, rif.tail_o);
        else pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_full();
        test_resolve();
        test_order();
        test_flush_en();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
